// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial CLA adder/subtractor.
//   state_t : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   NIB_W   : width of one CLA slice in bits
// -----------------------------------------------------------------------------
package cla_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : cla_pkg

// File: rtl/cla4_slice.sv
// -----------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
//   a, b   : nibble operands
//   c_in   : carry into bit 0
//   s      : nibble sum
//   c_out  : carry out of bit 3
//   c3_in  : carry into bit 3 (paired with c_out to detect signed overflow)
// -----------------------------------------------------------------------------
module cla4_slice
   import cla_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             c_in,
   output logic [NIB_W-1:0] s,
   output logic             c_out,
   output logic             c3_in
);

   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] p;
   logic [NIB_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is flattened into sum-of-products form so no carry waits on
   // the one below it.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign s     = p ^ c[NIB_W-1:0];
   assign c_out = c[4];
   assign c3_in = c[3];

endmodule : cla4_slice

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// Multi-cycle WIDTH-bit adder/subtractor. One shared 4-bit CLA slice is
// stepped across the operands, LSB nibble first, one nibble per clock, with a
// registered carry linking the nibbles. WIDTH must be a multiple of 4 and >= 8.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request pulse, accepted only while busy = 0
//   sub        : 0 = a + b, 1 = a - b (captured with start)
//   a, b       : operands (captured with start)
//   busy       : computation in progress
//   done       : one-cycle pulse, sum/c_out/ovf valid
//   sum        : result, held until the next accepted start
//   c_out      : carry out of the MSB (for subtraction 1 = no borrow)
//   ovf        : signed two's-complement overflow
// -----------------------------------------------------------------------------
module cla_seq_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int IDX_W = $clog2(NIB);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry_q;
   logic [IDX_W-1:0] idx;

   logic [NIB_W-1:0] slice_s;
   logic             slice_c;
   logic             slice_c3;

   // A start can only be taken while no computation is running.
   logic accept;
   assign accept = start && (state != ST_RUN);

   cla4_slice u_slice (
      .a     (op_a[NIB_W*idx +: NIB_W]),
      .b     (op_b[NIB_W*idx +: NIB_W]),
      .c_in  (carry_q),
      .s     (slice_s),
      .c_out (slice_c),
      .c3_in (slice_c3)
   );

   // NOTE: the operand copies are pure datapath storage that is always loaded
   // before it is read, so they are left without a reset; only control state
   // and visible outputs need a defined value after rst_n.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= a;
         op_b <= sub ? ~b : b;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         c_out   <= 1'b0;
         ovf     <= 1'b0;
         idx     <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (accept) begin
                  // Subtraction is a + ~b + 1: the +1 enters as carry-in.
                  carry_q <= sub;
                  idx     <= '0;
                  sum     <= '0;
                  busy    <= 1'b1;
                  state   <= ST_RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            ST_RUN: begin
               sum[NIB_W*idx +: NIB_W] <= slice_s;
               carry_q                 <= slice_c;
               if (idx == LAST_IDX) begin
                  c_out <= slice_c;
                  // Carries into and out of the sign bit disagree only on
                  // signed overflow.
                  ovf   <= slice_c ^ slice_c3;
                  idx   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : cla_seq_adder
